ddr_sa_offset_cal_ctrl: RTL and testbench
=========================================

# ddr_sa_offset_cal_ctrl

Offset-calibration sequencer for the 2-phase sense-amp receiver slice. Drives the slice's calibration enable and per-phase calibration code and direction. Sweeps both phases (0 and 180) concurrently from the most-negative to the most-positive signed offset, and majority-votes the slice data outputs at each step. Locks each phase at the first 0→1 decision flip. Sits beside the SA wrapper inside the DQ/CA receive lane and is started by the lane CSR block.

## Interface
Parameters:
- CODE_W, 4, magnitude width of each phase's calibration code; MAX = 2^CODE_W-1.
- SETTLE_CYC, 8, idle cycles after each code change before sampling (1..255).
- SAMPLE_N, 16, samples per step (2..255).

Ports:
- i_clk  in  1  lane clock; sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle start pulse.
- i_abort  in  1  single-cycle abort pulse.
- i_data_0  in  1  raw SA phase-0 data output (asynchronous to i_clk).
- i_data_180  in  1  raw SA phase-180 data output (asynchronous to i_clk).
- o_sa_cal_en  out  1  calibration enable to the slice.
- o_cal_code_0  out  CODE_W  phase-0 code magnitude.
- o_cal_dir_0  out  1  phase-0 direction; 1 = positive or zero.
- o_cal_code_180  out  CODE_W  phase-180 code magnitude.
- o_cal_dir_180  out  1  phase-180 direction.
- o_busy  out  1  sweep in progress.
- o_done  out  1  sticky completion flag; cleared by start, abort or reset.
- o_fail_0  out  1  phase-0 found no valid transition.
- o_fail_180  out  1  phase-180 found no valid transition.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, EVAL, DONE.
- IDLE/DONE + i_start:
  - clear done and fail flags;
  - set step index k=0 and clear lock flags;
  - go to SETTLE.
  - i_start is ignored while busy.
- Signed value v = k − MAX, with k in 0..2·MAX. Each unlocked phase drives code = |v| and dir = (v ≥ 0). Locked phases hold their captured code and dir.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: for SAMPLE_N cycles, add the synchronized data bit of each phase into that phase's ones-counter (width ⌈log2(SAMPLE_N+1)⌉). Then go to EVAL.
- EVAL (1 cycle): per phase, decision = (ones·2 ≥ SAMPLE_N). For each unlocked phase:
  - k=0 and decision=1: set fail, lock, and force code=0, dir=1.
  - k>0 and decision=1: lock at the current code/dir.
  - Clear the ones-counters.
  - If both phases are locked, go to DONE.
  - Else if k = 2·MAX: set fail for each still-unlocked phase, force it to code=0, dir=1, and go to DONE.
  - Else k++ and go to SETTLE.
- DONE: o_done=1, o_sa_cal_en=0, codes hold their final values until the next start or reset.
- i_abort in any non-IDLE state: go to IDLE next cycle with all codes 0, dirs 1, flags 0. Abort has priority over a same-cycle start.
- o_busy = (state ∈ {SETTLE, SAMPLE, EVAL}). o_sa_cal_en = o_busy.

## Timing
- Reset values:
  - o_sa_cal_en=0, o_busy=0, o_done=0, o_fail_0=0, o_fail_180=0;
  - o_cal_code_0=0, o_cal_code_180=0;
  - o_cal_dir_0=1, o_cal_dir_180=1.
  - State is IDLE.
- Reset asserted mid-sweep takes effect at the next edge, identical to power-on.
- Start→o_busy: 1 cycle. First code is driven the same cycle o_busy rises.
- Per-step duration: SETTLE_CYC + SAMPLE_N + 1 cycles. Code outputs change only on the EVAL→SETTLE edge.
- A full unlocked sweep takes (2·MAX+1)·(SETTLE_CYC+SAMPLE_N+1) cycles, plus 1 to enter DONE.
- All outputs are registered.

## Configuration
- DDR_SA_CAL_SYNC_EN defined: i_data_0 and i_data_180 each pass through a 2-flop synchronizer. The synchronizer latency is absorbed by SETTLE_CYC; SETTLE_CYC < 3 is illegal and is flagged by an elaboration assertion.
- Not defined: each input is sampled by a single flop (behavioural/zero-delay simulation only). The FSM is otherwise identical.

## Test plan
- CODE_W=4, SETTLE_CYC=8, SAMPLE_N=16. Both data inputs model a comparator that goes high at v ≥ +3 → o_cal_code_0=3, dir_0=1, same for 180. o_done rises after 19·25+1 cycles from start. No fails.
- Phase-0 flips at v=−5, phase-180 at v=+7 → phase 0 locks at code 5/dir 0 and holds while phase 180 continues sweeping; 180 locks at 7/dir 1. Done at the step where k=22.
- Phase-0 input held high → fail_0=1 after the first EVAL with code 0/dir 1. Phase-180 input held low → fail_180=1 at k=30, code 0/dir 1.
- Input with 8/16 ones at v=0 and 7/16 ones at v=−1 → lock at code 0, dir 1 (tie counts as 1).
- i_abort at k=10 mid-SAMPLE → next cycle IDLE, busy=0, cal_en=0, codes 0. A same-cycle i_start is ignored. A later start runs a full sweep.
- i_rst asserted in EVAL, and i_start pulsed while busy → reset values on the next edge; the busy-time start produces no restart and no counter disturbance.

Source files
------------

// File: rtl/ddr_sa_offset_cal_ctrl.sv
// Sense-amp offset calibration sequencer: sweeps both phases from -MAX to +MAX and locks each at its first majority-vote 0->1 flip.
// Optional DDR_SA_CAL_SYNC_EN puts a 2-flop synchronizer on each raw data input (default: single sampling flop).

module ddr_sa_offset_cal_phase #(
  parameter int CODE_W   = 4,
  parameter int SAMPLE_N = 16,
  parameter int ONES_W   = $clog2(SAMPLE_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              sample,
  input  logic              eval,
  input  logic              k_zero,
  input  logic              sweep_end,
  input  logic              advance,
  input  logic [CODE_W-1:0] step_code,
  input  logic              step_dir,
  input  logic              data,
  output logic              lock_nxt,
  output logic [CODE_W-1:0] code,
  output logic              dir,
  output logic              fail
);
  localparam logic [CODE_W-1:0] MAX      = '1;
  localparam logic [ONES_W:0]   HALF_THR = (ONES_W + 1)'(SAMPLE_N);

  logic              data_s;
  logic [ONES_W-1:0] ones;
  logic              locked;
  logic              dec;

`ifdef DDR_SA_CAL_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], data};
  end
  assign data_s = sync_q[1];
`else
  logic data_q;
  always_ff @(posedge clk) begin
    if (rst) data_q <= 1'b0;
    else     data_q <= data;
  end
  assign data_s = data_q;
`endif

  // ones*2 >= SAMPLE_N, so an exact half counts as a 1 decision
  assign dec      = {ones, 1'b0} >= HALF_THR;
  assign lock_nxt = locked | dec;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ones   <= '0;
      locked <= 1'b0;
      fail   <= 1'b0;
      code   <= '0;
      dir    <= 1'b1;
    end else if (load) begin
      ones   <= '0;
      locked <= 1'b0;
      fail   <= 1'b0;
      code   <= MAX;
      dir    <= 1'b0;
    end else begin
      if (sample) ones <= ones + {{(ONES_W-1){1'b0}}, data_s};
      if (eval) begin
        ones <= '0;
        if (!locked && dec) begin
          locked <= 1'b1;
          // a 1 already at the most-negative code means no real transition exists
          if (k_zero) begin
            fail <= 1'b1;
            code <= '0;
            dir  <= 1'b1;
          end
        end else if (!locked && sweep_end) begin
          fail <= 1'b1;
          code <= '0;
          dir  <= 1'b1;
        end else if (!locked && advance) begin
          code <= step_code;
          dir  <= step_dir;
        end
      end
    end
  end
endmodule

module ddr_sa_offset_cal_ctrl #(
  parameter int CODE_W     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_N   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_data_0,
  input  logic              i_data_180,
  output logic              o_sa_cal_en,
  output logic [CODE_W-1:0] o_cal_code_0,
  output logic              o_cal_dir_0,
  output logic [CODE_W-1:0] o_cal_code_180,
  output logic              o_cal_dir_180,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail_0,
  output logic              o_fail_180
);
  localparam int              NUM_PH = 2;
  localparam int              K_W    = CODE_W + 1;
  localparam logic [K_W-1:0]  MAX_K  = K_W'((1 << CODE_W) - 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(2 * ((1 << CODE_W) - 1));
  localparam logic [7:0]      SET_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]      SMP_LAST = 8'(SAMPLE_N - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef DDR_SA_CAL_SYNC_EN
  if (SETTLE_CYC < 3) begin : g_settle_chk
    $error("SETTLE_CYC must be >= 3 when the data synchronizer is enabled");
  end
`endif

  logic [2:0]                     state, state_nxt;
  logic [7:0]                     cnt;
  logic [K_W-1:0]                 k, kn;
  logic                           start_req, abort_req, eval, all_lock;
  logic                           sweep_end, advance, busy_nxt;
  logic [CODE_W-1:0]              step_code;
  logic                           step_dir;
  logic [NUM_PH-1:0]              data, lock_nxt, dir_q, fail_q;
  logic [NUM_PH-1:0][CODE_W-1:0]  code_q;

  assign data      = {i_data_180, i_data_0};
  assign abort_req = i_abort && (state != ST_IDLE);
  assign start_req = i_start && !i_abort && (state == ST_IDLE || state == ST_DONE);
  assign eval      = (state == ST_EVAL);
  assign all_lock  = &lock_nxt;
  assign sweep_end = eval && !all_lock && (k == K_LAST);
  assign advance   = eval && !all_lock && (k != K_LAST);

  // signed step value for the next index: v = (k+1) - MAX as magnitude/direction
  assign kn = k + K_W'(1);
  always_comb begin
    step_code = '0;
    step_dir  = 1'b1;
    if (kn >= MAX_K) begin
      step_code = CODE_W'(kn - MAX_K);
      step_dir  = 1'b1;
    end else begin
      step_code = CODE_W'(MAX_K - kn);
      step_dir  = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_req) state_nxt = ST_SETTLE;
      ST_SETTLE:        if (cnt == SET_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE:        if (cnt == SMP_LAST) state_nxt = ST_EVAL;
      ST_EVAL:          state_nxt = (all_lock || k == K_LAST) ? ST_DONE : ST_SETTLE;
      default:          state_nxt = ST_IDLE;
    endcase
    if (abort_req) state_nxt = ST_IDLE;
  end

  assign busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE) || (state_nxt == ST_EVAL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      k           <= '0;
      o_busy      <= 1'b0;
      o_sa_cal_en <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state || !busy_nxt) ? '0 : cnt + 8'd1;
      o_busy      <= busy_nxt;
      o_sa_cal_en <= busy_nxt;
      o_done      <= (state_nxt == ST_DONE);
      if (start_req)    k <= '0;
      else if (advance) k <= kn;
    end
  end

  for (genvar p = 0; p < NUM_PH; p++) begin : g_ph
    ddr_sa_offset_cal_phase #(
      .CODE_W   (CODE_W),
      .SAMPLE_N (SAMPLE_N)
    ) u_ph (
      .clk       (i_clk),
      .rst       (i_rst),
      .clr       (abort_req),
      .load      (start_req),
      .sample    (state == ST_SAMPLE),
      .eval      (eval),
      .k_zero    (k == '0),
      .sweep_end (sweep_end),
      .advance   (advance),
      .step_code (step_code),
      .step_dir  (step_dir),
      .data      (data[p]),
      .lock_nxt  (lock_nxt[p]),
      .code      (code_q[p]),
      .dir       (dir_q[p]),
      .fail      (fail_q[p])
    );
  end

  assign o_cal_code_0   = code_q[0];
  assign o_cal_dir_0    = dir_q[0];
  assign o_fail_0       = fail_q[0];
  assign o_cal_code_180 = code_q[1];
  assign o_cal_dir_180  = dir_q[1];
  assign o_fail_180     = fail_q[1];
endmodule

// File: tb/tb_ddr_sa_offset_cal_ctrl.sv
// Scoreboard bench: a per-step ones table drives each phase; a sweep model predicts the end-of-run outputs.
module tb_ddr_sa_offset_cal_ctrl;
  localparam int CODE_W = 4, SETTLE_CYC = 8, SAMPLE_N = 16;
  localparam int MAX = (1 << CODE_W) - 1;
  localparam int NK = 2 * MAX + 1;
  localparam int STEP = SETTLE_CYC + SAMPLE_N + 1;

  typedef struct { int done, f0, f1, c0, d0, c1, d1, lat; } exp_t;

  logic clk = 0, i_rst = 1, i_start = 0, i_abort = 0, i_data_0 = 0, i_data_180 = 0;
  logic o_sa_cal_en, o_cal_dir_0, o_cal_dir_180, o_busy, o_done, o_fail_0, o_fail_180;
  logic [CODE_W-1:0] o_cal_code_0, o_cal_code_180;

  int tab [2][NK];
  int rot [2][NK];
  int cyc = 0, st_cyc = 0, tick = 0, checks = 0, failures = 0;
  logic busy_prev = 0;
  exp_t exp_q[$];

  ddr_sa_offset_cal_ctrl #(.CODE_W(CODE_W), .SETTLE_CYC(SETTLE_CYC), .SAMPLE_N(SAMPLE_N)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_data_0(i_data_0), .i_data_180(i_data_180), .o_sa_cal_en(o_sa_cal_en),
    .o_cal_code_0(o_cal_code_0), .o_cal_dir_0(o_cal_dir_0),
    .o_cal_code_180(o_cal_code_180), .o_cal_dir_180(o_cal_dir_180),
    .o_busy(o_busy), .o_done(o_done), .o_fail_0(o_fail_0), .o_fail_180(o_fail_180));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Slice model: a period-SAMPLE_N pattern, so any SAMPLE_N-sample window at a held code has exactly tab[] ones.
  function automatic logic env_bit(input int p, input logic [CODE_W-1:0] c, input logic d);
    int v, k;
    v = d ? int'(c) : -int'(c);
    k = v + MAX;
    return ((tick + rot[p][k]) % SAMPLE_N) < tab[p][k];
  endfunction

  always @(negedge clk) begin
    tick++;
    i_data_0   = env_bit(0, o_cal_code_0, o_cal_dir_0);
    i_data_180 = env_bit(1, o_cal_code_180, o_cal_dir_180);
  end

  // Monitor: every busy fall ends a run and is matched against the oldest prediction.
  always @(negedge clk) begin
    if (busy_prev && !o_busy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_end: busy fell with no run outstanding at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done", int'(o_done), e.done);
        chk("fail_0", int'(o_fail_0), e.f0);
        chk("fail_180", int'(o_fail_180), e.f1);
        chk("code_0", int'(o_cal_code_0), e.c0);
        chk("dir_0", int'(o_cal_dir_0), e.d0);
        chk("code_180", int'(o_cal_code_180), e.c1);
        chk("dir_180", int'(o_cal_dir_180), e.d1);
        chk("cal_en_end", int'(o_sa_cal_en), 0);
        chk("latency", cyc - st_cyc, e.lat);
      end
    end
    busy_prev = o_busy;
  end

  function automatic exp_t model();
    exp_t e;
    int lk[2], c[2], d[2], f[2];
    int steps;
    bit fin;
    lk = '{0, 0}; f = '{0, 0}; c = '{0, 0}; d = '{1, 1};
    steps = NK; fin = 0;
    for (int k = 0; k < NK; k++) begin
      if (!fin) begin
        for (int p = 0; p < 2; p++) begin
          if (lk[p] == 0 && tab[p][k] * 2 >= SAMPLE_N) begin
            lk[p] = 1;
            if (k == 0) begin f[p] = 1; c[p] = 0; d[p] = 1; end
            else begin c[p] = (k < MAX) ? MAX - k : k - MAX; d[p] = (k >= MAX); end
          end
        end
        if (lk[0] == 1 && lk[1] == 1) begin steps = k + 1; fin = 1; end
      end
    end
    for (int p = 0; p < 2; p++)
      if (lk[p] == 0) begin f[p] = 1; c[p] = 0; d[p] = 1; end
    e = '{done: 1, f0: f[0], f1: f[1], c0: c[0], d0: d[0], c1: c[1], d1: d[1], lat: steps * STEP + 1};
    return e;
  endfunction

  task automatic set_thr(input int p, input int t, input bit margin);
    for (int k = 0; k < NK; k++) begin
      if (k - MAX >= t) tab[p][k] = margin ? int'($urandom_range(SAMPLE_N / 2, SAMPLE_N)) : SAMPLE_N;
      else              tab[p][k] = margin ? int'($urandom_range(0, SAMPLE_N / 2 - 1)) : 0;
      rot[p][k] = int'($urandom_range(0, SAMPLE_N - 1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_cal_en"}, int'(o_sa_cal_en), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_fails"}, int'({o_fail_0, o_fail_180}), 0);
    chk({tag, "_codes"}, int'({o_cal_code_0, o_cal_code_180}), 0);
    chk({tag, "_dirs"}, int'({o_cal_dir_0, o_cal_dir_180}), 3);
  endtask

  // j counts cycles after the start pulse; extra controls are driven in cycle j when j matches.
  task automatic run(input int mid_start_at, input int spot_at, input int abort_at, input int rst_at);
    exp_t e;
    e = model();
    if (abort_at > 0 || rst_at > 0)
      e = '{done: 0, f0: 0, f1: 0, c0: 0, d0: 1, c1: 0, d1: 1,
            lat: ((abort_at > 0) ? abort_at : rst_at) + 1};
    exp_q.push_back(e);
    @(posedge clk); #1; i_start = 1; st_cyc = cyc;
    @(posedge clk); #1; i_start = 0;
    chk("first_busy", int'(o_busy), 1);
    chk("first_code_0", int'(o_cal_code_0), MAX);
    chk("first_dir_180", int'(o_cal_dir_180), 0);
    for (int j = 2; j <= 1200 && exp_q.size() > 0; j++) begin
      @(posedge clk); #1;
      i_start = (j == mid_start_at) || (j == abort_at);
      i_abort = (j == abort_at);
      i_rst   = (j == rst_at);
      if (j == spot_at) begin
        chk("hold_code_0", int'(o_cal_code_0), 5);
        chk("hold_dir_0", int'(o_cal_dir_0), 0);
        chk("sweep_code_180", int'(o_cal_code_180), 0);
        chk("sweep_dir_180", int'(o_cal_dir_180), 1);
      end
    end
    i_start = 0; i_abort = 0; i_rst = 0;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL run_timeout: run did not end within budget, outstanding=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 i_rst = 0;
    chk_reset_vals("por");

    set_thr(0, 3, 0); set_thr(1, 3, 0);        run(40, 0, 0, 0);   // both lock at +3, busy start ignored
    set_thr(0, -5, 0); set_thr(1, 7, 0);       run(0, 386, 0, 0);  // phase 0 holds while 180 sweeps on
    set_thr(0, -MAX, 0); set_thr(1, MAX + 1, 0); run(0, 0, 0, 0);  // 0 fails at k=0, 180 never flips
    for (int p = 0; p < 2; p++) begin
      set_thr(p, 0, 0);
      tab[p][MAX] = SAMPLE_N / 2;
      tab[p][MAX - 1] = SAMPLE_N / 2 - 1;
    end
    run(0, 0, 0, 0);

    set_thr(0, 3, 0); set_thr(1, 3, 0);
    run(0, 0, 10 * STEP + 16, 0);                                  // abort mid-SAMPLE at k=10
    repeat (2) @(negedge clk);
    chk("abort_no_restart_busy", int'(o_busy), 0);
    chk("abort_no_restart_done", int'(o_done), 0);

    set_thr(0, MAX + 1, 0); set_thr(1, MAX + 1, 0); run(0, 0, 0, 0);
    set_thr(0, 5, 0); set_thr(1, 5, 0);        run(40, 0, 0, 3 * STEP + STEP);  // reset during EVAL at k=3
    chk_reset_vals("mid_rst");

    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int k = 0; k < NK; k++) begin
            tab[p][k] = int'($urandom_range(0, SAMPLE_N));
            rot[p][k] = int'($urandom_range(0, SAMPLE_N - 1));
          end
        end else set_thr(p, int'($urandom_range(0, NK)) - MAX, 1);
      end
      run(0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
